id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register and operand-resolution stage directly upstream of the ALU.

---
 rtl/id_ex_operand_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register and operand-resolution stage that sits directly in
//   front of the ALU. It latches the decoded instruction fields and resolves the
//   ALU operands by forwarding from the EX/MEM and MEM/WB stages. It also detects
//   load-use hazards and inserts bubbles on a load-use hazard or a flush.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   id_*                       decoded instruction fields from the ID stage
//   stall, flush               hold / squash the stage contents
//   mem_rd_addr/_reg_write/_fwd_data   EX/MEM forwarding source
//   wb_rd_addr/_reg_write/wb_data      MEM/WB forwarding source
//   SrcA, SrcB, Operation      ALU operands and operation code
//   ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read, ex_store_data
//                              EX-stage control and store data
//   load_use_hazard            combinational; upstream holds IF/ID while it is 1
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic                     id_a_sel,
  input  logic                     id_b_sel,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic [REG_ADDR_W-1:0]    id_rd_addr,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    mem_rd_addr,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_fwd_data,
  input  logic [REG_ADDR_W-1:0]    wb_rd_addr,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd_addr,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     load_use_hazard
);

  logic                     r_valid_p1;
  logic [REG_ADDR_W-1:0]    r_rs1_addr_p1;
  logic [REG_ADDR_W-1:0]    r_rs2_addr_p1;
  logic [DATA_WIDTH-1:0]    r_rs1_data_p1;
  logic [DATA_WIDTH-1:0]    r_rs2_data_p1;
  logic [DATA_WIDTH-1:0]    r_imm_p1;
  logic [DATA_WIDTH-1:0]    r_pc_p1;
  logic                     r_a_sel_p1;
  logic                     r_b_sel_p1;
  logic [OPCODE_LENGTH-1:0] r_alu_op_p1;
  logic [REG_ADDR_W-1:0]    r_rd_addr_p1;
  logic                     r_reg_write_p1;
  logic                     r_mem_read_p1;

  logic [DATA_WIDTH-1:0]    w_fwd_rs1;
  logic [DATA_WIDTH-1:0]    w_fwd_rs2;
  logic                     w_load_use;

  // Newest producer wins: EX/MEM, then MEM/WB, then the value read in ID.
  // x0 is hard-wired to zero, so a write targeting it is never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [DATA_WIDTH-1:0] reg_val,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic [DATA_WIDTH-1:0] m_val,
    input logic                  w_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic [DATA_WIDTH-1:0] w_val
  );
    logic [DATA_WIDTH-1:0] res;
    res = reg_val;
    if (m_we && (m_rd != '0) && (m_rd == rs)) begin
      res = m_val;
    end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
      res = w_val;
    end
    return res;
  endfunction

  always_comb begin
    w_fwd_rs1 = fwd_operand(r_rs1_addr_p1, r_rs1_data_p1, mem_reg_write, mem_rd_addr,
                            mem_fwd_data, wb_reg_write, wb_rd_addr, wb_data);
    w_fwd_rs2 = fwd_operand(r_rs2_addr_p1, r_rs2_data_p1, mem_reg_write, mem_rd_addr,
                            mem_fwd_data, wb_reg_write, wb_rd_addr, wb_data);
  end

  // rs2 is compared even when the instruction uses the immediate; a store
  // still needs rs2 as its data.
  assign w_load_use = r_valid_p1 && r_mem_read_p1 && (r_rd_addr_p1 != '0) && id_valid &&
                      ((id_rs1_addr == r_rd_addr_p1) || (id_rs2_addr == r_rd_addr_p1));

  // ---- ID -> EX register (p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_p1     <= 1'b0;
      r_rs1_addr_p1  <= '0;
      r_rs2_addr_p1  <= '0;
      r_rs1_data_p1  <= '0;
      r_rs2_data_p1  <= '0;
      r_imm_p1       <= '0;
      r_pc_p1        <= '0;
      r_a_sel_p1     <= 1'b0;
      r_b_sel_p1     <= 1'b0;
      r_alu_op_p1    <= '0;
      r_rd_addr_p1   <= '0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
    end else if (flush || (!stall && w_load_use)) begin
      // Bubble: only the fields that can cause side effects are cleared.
      r_valid_p1     <= 1'b0;
      r_alu_op_p1    <= '0;
      r_rd_addr_p1   <= '0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
    end else if (stall) begin
      // A producer may retire through WB while we are held; capture the
      // forwarded value now or it is gone once the stall releases.
      r_rs1_data_p1  <= w_fwd_rs1;
      r_rs2_data_p1  <= w_fwd_rs2;
    end else begin
      r_valid_p1     <= id_valid;
      r_rs1_addr_p1  <= id_rs1_addr;
      r_rs2_addr_p1  <= id_rs2_addr;
      r_rs1_data_p1  <= id_rs1_data;
      r_rs2_data_p1  <= id_rs2_data;
      r_imm_p1       <= id_imm;
      r_pc_p1        <= id_pc;
      r_a_sel_p1     <= id_a_sel;
      r_b_sel_p1     <= id_b_sel;
      r_alu_op_p1    <= id_alu_op;
      r_rd_addr_p1   <= id_rd_addr;
      r_reg_write_p1 <= id_reg_write;
      r_mem_read_p1  <= id_mem_read;
    end
  end

  // ---- EX operand outputs (p1, combinational) ----
  assign SrcA            = r_a_sel_p1 ? r_pc_p1  : w_fwd_rs1;
  assign SrcB            = r_b_sel_p1 ? r_imm_p1 : w_fwd_rs2;
  assign ex_store_data   = w_fwd_rs2;
  assign Operation       = r_alu_op_p1;
  assign ex_valid        = r_valid_p1;
  assign ex_rd_addr      = r_rd_addr_p1;
  assign ex_reg_write    = r_reg_write_p1;
  assign ex_mem_read     = r_mem_read_p1;
  assign load_use_hazard = w_load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: table-driven forwarding/operand vectors
// plus directed sequences for reset, load-use, stall, flush and reset-in-stall.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read;
  logic [3:0]  id_alu_op;
  logic        stall, flush;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_fwd_data, wb_data;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_alu_op(id_alu_op), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .stall(stall), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_fwd_data(mem_fwd_data),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a_sel, b_sel, rs1, rs2, rs1_d, rs2_d, imm, pc, op, rd;
    logic [31:0] m_rd, m_we, m_d, w_rd, w_we, w_d;
    logic [31:0] exp_a, exp_b, exp_sd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    mem_rd_addr = '0; mem_reg_write = 1'b0; mem_fwd_data = '0;
    wb_rd_addr  = '0; wb_reg_write  = 1'b0; wb_data      = '0;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic asel, input logic bsel, input logic [3:0] op,
                          input logic [4:0] rd, input logic we, input logic mr);
    id_valid = 1'b1;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_pc = pc; id_a_sel = asel; id_b_sel = bsel;
    id_alu_op = op; id_rd_addr = rd; id_reg_write = we; id_mem_read = mr;
  endtask

  initial begin
    // Fields: a_sel b_sel rs1 rs2 rs1_d rs2_d imm pc op rd | m_rd m_we m_d | w_rd w_we w_d | exp_a exp_b exp_sd
    vecs[0] = '{0,0,3,2,'h1111,'h2222,'h7,'h1000,'h1,'h9, 3,1,'h30, 0,0,0, 'h30,'h2222,'h2222};
    vecs[1] = '{0,0,1,4,'h5,'h4444,0,0,'h2,'ha, 4,1,'h11, 4,1,'h22, 'h5,'h11,'h11};
    vecs[2] = '{0,0,0,0,0,0,0,0,'h3,'hb, 0,1,'hdead, 0,1,'hbeef, 0,0,0};
    vecs[3] = '{0,0,6,8,'h66,'h88,0,0,'h4,'hc, 6,0,'h99, 6,1,'h77, 'h77,'h88,'h88};
    vecs[4] = '{1,1,5,5,'h51,'h55,'hABCDE,'h100,'h5,'hd, 5,1,'h500, 0,0,0, 'h100,'hABCDE,'h500};
    vecs[5] = '{0,0,'h1f,9,'hFFFFFFF0,'h99,0,0,'hf,'h1f, 9,0,'h1, 9,1,'h80000000,
                'hFFFFFFF0,'h80000000,'h80000000};
    vecs[6] = '{0,0,2,2,'h20,'h20,0,0,'h6,'h1, 2,1,'hA1, 2,1,'hB2, 'hA1,'hA1,'hA1};
    vecs[7] = '{0,1,'hE,'hE,'h3,'h4,'hFFFFF800,0,'h7,'h2, 'hF,1,'h123, 'hD,1,'h456,
                'h3,'hFFFFF800,'h4};

    // Reset held for two cycles with a live-looking instruction on the inputs.
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(5'd3, 5'd4, 32'h55, 32'h66, 32'h77, 32'h88, 1'b0, 1'b0, 4'h9, 5'd6, 1'b1, 1'b1);
    clear_fwd();
    tick(); tick();
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_op", {28'b0, Operation}, 32'd0);
    check("rst_srca", SrcA, 32'd0);
    check("rst_srcb", SrcB, 32'd0);
    check("rst_hazard", {31'b0, load_use_hazard}, 32'd0);
    check("rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
    reset = 1'b0;

    // Forwarding/operand-select table.
    for (int i = 0; i < 8; i++) begin
      clear_fwd();
      drive_id(vecs[i].rs1[4:0], vecs[i].rs2[4:0], vecs[i].rs1_d, vecs[i].rs2_d,
               vecs[i].imm, vecs[i].pc, vecs[i].a_sel[0], vecs[i].b_sel[0],
               vecs[i].op[3:0], vecs[i].rd[4:0], 1'b1, 1'b0);
      tick();
      id_valid = 1'b0;
      mem_rd_addr = vecs[i].m_rd[4:0]; mem_reg_write = vecs[i].m_we[0]; mem_fwd_data = vecs[i].m_d;
      wb_rd_addr  = vecs[i].w_rd[4:0]; wb_reg_write  = vecs[i].w_we[0]; wb_data      = vecs[i].w_d;
      #1;
      check($sformatf("vec%0d_srca", i), SrcA, vecs[i].exp_a);
      check($sformatf("vec%0d_srcb", i), SrcB, vecs[i].exp_b);
      check($sformatf("vec%0d_store", i), ex_store_data, vecs[i].exp_sd);
      check($sformatf("vec%0d_op", i), {28'b0, Operation}, vecs[i].op);
      check($sformatf("vec%0d_valid", i), {31'b0, ex_valid}, 32'd1);
    end
    clear_fwd();

    // Load-use: EX load to x5, ID reads x5 through rs2 while using the immediate.
    drive_id(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 5'd5, 1'b1, 1'b1);
    tick();
    id_valid = 1'b0;
    #1;
    check("lu_no_id_valid", {31'b0, load_use_hazard}, 32'd0);
    drive_id(5'd6, 5'd5, 32'h0, 32'h0, 32'h123, 32'h0, 1'b0, 1'b1, 4'h3, 5'd7, 1'b1, 1'b0);
    #1;
    check("lu_hazard", {31'b0, load_use_hazard}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    check("lu_bubble_reg_write", {31'b0, ex_reg_write}, 32'd0);
    check("lu_bubble_mem_read", {31'b0, ex_mem_read}, 32'd0);
    check("lu_bubble_op", {28'b0, Operation}, 32'd0);
    check("lu_hazard_cleared", {31'b0, load_use_hazard}, 32'd0);
    tick();
    check("lu_issue_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_issue_op", {28'b0, Operation}, 32'd3);
    check("lu_issue_rd", {27'b0, ex_rd_addr}, 32'd7);
    check("lu_issue_srcb", SrcB, 32'h123);

    // Stall 3 cycles; WB retires x7=0xAB during the first stall cycle only.
    drive_id(5'd7, 5'd0, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h2, 5'd8, 1'b1, 1'b0);
    tick();
    stall = 1'b1;
    drive_id(5'd9, 5'd0, 32'h999, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h9, 5'd9, 1'b1, 1'b0);
    wb_rd_addr = 5'd7; wb_reg_write = 1'b1; wb_data = 32'hAB;
    tick();
    clear_fwd();
    tick(); tick();
    stall = 1'b0; id_valid = 1'b0;
    #1;
    check("stall_srca", SrcA, 32'hAB);
    check("stall_op_held", {28'b0, Operation}, 32'd2);
    check("stall_rd_held", {27'b0, ex_rd_addr}, 32'd8);
    check("stall_valid_held", {31'b0, ex_valid}, 32'd1);

    // Flush and stall together: flush wins.
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    check("flush_stall_valid", {31'b0, ex_valid}, 32'd0);
    check("flush_stall_op", {28'b0, Operation}, 32'd0);
    check("flush_stall_reg_write", {31'b0, ex_reg_write}, 32'd0);
    check("flush_stall_rd", {27'b0, ex_rd_addr}, 32'd0);

    // Reset arriving in the middle of a stall empties the stage.
    drive_id(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 4'h5, 5'd3, 1'b1, 1'b0);
    tick();
    stall = 1'b1; id_valid = 1'b0;
    tick();
    check("rst_stall_pre_valid", {31'b0, ex_valid}, 32'd1);
    check("rst_stall_pre_srca", SrcA, 32'h40);
    reset = 1'b1;
    tick();
    check("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_stall_op", {28'b0, Operation}, 32'd0);
    check("rst_stall_srca", SrcA, 32'd0);
    reset = 1'b0; stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
